// File: rtl/gf2_poly_div_127by64_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf2_pkg : shared widths, FSM encoding and index-width helper for GF(2) divider
// Revision: 1.0
// ---------------------------------------------------------------------------
package gf2_pkg;

  localparam int DW_DEF = 127;
  localparam int VW_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int msb_idx_w(input int vw);
    return (vw > 1) ? $clog2(vw) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf2_poly_div_127by64_msb_index.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf2_msb_index : combinational priority encoder, index of highest set bit
// Revision: 1.0
// ---------------------------------------------------------------------------
module gf2_msb_index
  import gf2_pkg::*;
#(
  parameter int VW = VW_DEF,
  parameter int IW = msb_idx_w(VW)
) (
  input  logic [VW-1:0] vec_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o
);

  // Later (higher) set bits overwrite earlier ones, leaving the MSB index.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < VW; i++) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule
`default_nettype wire

// File: rtl/gf2_poly_div_127by64.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf2_poly_div_127by64 : sequential GF(2)[x] long divider, STEPS quotient bits/cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module gf2_poly_div_127by64
  import gf2_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int VW    = VW_DEF,
  parameter int STEPS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] quotient_o,
  output logic [VW-1:0] remainder_o,
  output logic          div_by_zero_o
);

  localparam int N  = (DW + STEPS - 1) / STEPS;
  localparam int P  = N * STEPS;
  localparam int IW = msb_idx_w(VW);
  localparam int CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [P-1:0]  dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] r_q, r_d;
  logic [P-1:0]  q_q, q_d;
  logic [IW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [IW-1:0] w_idx;
  logic          w_zero;

  gf2_msb_index #(
    .VW (VW),
    .IW (IW)
  ) u_msb (
    .vec_i  (dvs_q),
    .idx_o  (w_idx),
    .zero_o (w_zero)
  );

  // Unrolled reduction chain; since r < x^d always holds, bit d is the only trigger.
  logic [VW-1:0]    w_r [STEPS+1];
  logic [STEPS-1:0] w_qb;
  logic [P-1:0]     w_qext;

  assign w_r[0] = r_q;

  for (genvar s = 0; s < STEPS; s++) begin : g_step
    logic [VW-1:0] w_sh;
    assign w_sh            = (w_r[s] << 1) | {{(VW-1){1'b0}}, dvd_q[P-1-s]};
    assign w_qb[STEPS-1-s] = w_sh[d_q];
    assign w_r[s+1]        = w_sh[d_q] ? (w_sh ^ dvs_q) : w_sh;
  end

  always_comb begin
    w_qext             = '0;
    w_qext[STEPS-1:0]  = w_qb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          dvd_d          = '0;
          dvd_d[DW-1:0]  = dividend_i;
          dvs_d          = divisor_i;
          r_d            = '0;
          q_d            = '0;
          dbz_d          = 1'b0;
          state_d        = ST_NORM;
        end
      end
      ST_NORM: begin
        d_d = w_idx;
        if (w_zero) begin
          dbz_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = CW'(N);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        dvd_d = dvd_q << STEPS;
        r_d   = w_r[STEPS];
        q_d   = (q_q << STEPS) | w_qext;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready_o    = (state_q == ST_IDLE);
  assign out_valid_o   = (state_q == ST_DONE);
  assign quotient_o    = q_q[DW-1:0];
  assign remainder_o   = r_q;
  assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_gf2_poly_div_127by64.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gf2_poly_div_127by64 : directed self-checking bench, STEPS=1 and STEPS=4 DUTs
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gf2_poly_div_127by64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, dbz;
  logic [126:0] dividend, quotient;
  logic [63:0]  divisor, remainder;

  logic         in_valid4, in_ready4, out_valid4, out_ready4, dbz4;
  logic [126:0] dividend4, quotient4;
  logic [63:0]  divisor4, remainder4;

  int checks = 0;
  int errors = 0;

  gf2_poly_div_127by64 #(.DW(127), .VW(64), .STEPS(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dbz)
  );

  gf2_poly_div_127by64 #(.DW(127), .VW(64), .STEPS(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid4),
    .in_ready_o    (in_ready4),
    .dividend_i    (dividend4),
    .divisor_i     (divisor4),
    .out_valid_o   (out_valid4),
    .out_ready_i   (out_ready4),
    .quotient_o    (quotient4),
    .remainder_o   (remainder4),
    .div_by_zero_o (dbz4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [126:0] clmul(input logic [63:0] a, input logic [63:0] b);
    logic [126:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) if (b[i]) p ^= ({63'b0, a} << i);
    return p;
  endfunction

  // Textbook long division from the top coefficient downward.
  task automatic ref_div(input logic [126:0] n, input logic [63:0] b,
                         output logic [126:0] q, output logic [63:0] r);
    logic [126:0] rem;
    int d;
    d = 0;
    for (int i = 0; i < 64; i++) if (b[i]) d = i;
    rem = n;
    q   = '0;
    for (int i = 126; i >= d; i--) begin
      if (rem[i]) begin
        rem      ^= ({63'b0, b} << (i - d));
        q[i - d]  = 1'b1;
      end
    end
    r = rem[63:0];
  endtask

  task automatic op1(input logic [126:0] a, input logic [63:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 500) begin @(posedge clk); #1; guard++; end
    @(negedge clk);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = '1; divisor = '1;
    lat = 0;
    while (!out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    if (!out_valid) chk("timeout1", 128'(out_valid), 128'(1));
  endtask

  task automatic op4(input logic [126:0] a, input logic [63:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready4 && guard < 500) begin @(posedge clk); #1; guard++; end
    @(negedge clk);
    in_valid4 = 1'b1; dividend4 = a; divisor4 = b;
    @(posedge clk); #1;
    in_valid4 = 1'b0; dividend4 = '1; divisor4 = '1;
    lat = 0;
    while (!out_valid4 && lat < 400) begin @(posedge clk); #1; lat++; end
    if (!out_valid4) chk("timeout4", 128'(out_valid4), 128'(1));
  endtask

  task automatic release1(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_rdy"}, 128'(in_ready), 128'(1));
    chk({tag, "_ov"}, 128'(out_valid), 128'(0));
  endtask

  task automatic release4(input string tag);
    @(negedge clk); out_ready4 = 1'b1;
    @(posedge clk); #1; out_ready4 = 1'b0;
    chk({tag, "_rdy"}, 128'(in_ready4), 128'(1));
  endtask

  task automatic res1(input string tag, input logic [126:0] q, input logic [63:0] r, input logic z);
    chk({tag, "_q"}, {1'b0, quotient}, {1'b0, q});
    chk({tag, "_r"}, 128'(remainder), 128'(r));
    chk({tag, "_dbz"}, 128'(dbz), 128'(z));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [126:0] eq, rnd;
    logic [63:0]  er, a, b;
    logic [127:0] wide;

    rst = 1'b1;
    in_valid = 1'b0;  out_ready = 1'b0;  dividend = '0;  divisor = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; dividend4 = '0; divisor4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 128'(in_ready), 128'(1));
    chk("rst_ov", 128'(out_valid), 128'(0));
    res1("rst", '0, '0, 1'b0);
    rst = 1'b0;

    // (x^2+1) / (x+1) = x+1
    op1(127'h5, 64'h3, lat);
    chk("lat_s1", 128'(lat), 128'(128));
    res1("v5_3", 127'h3, 64'h0, 1'b0);
    release1("v5_3");

    op1(127'h7, 64'h3, lat);
    res1("v7_3", 127'h2, 64'h1, 1'b0);
    release1("v7_3");

    op1(127'h1, 64'h3, lat);
    res1("v1_3", 127'h0, 64'h1, 1'b0);
    release1("v1_3");

    op1({127{1'b1}}, 64'h1, lat);
    res1("ones_1", {127{1'b1}}, 64'h0, 1'b0);
    release1("ones_1");

    op1({127{1'b1}}, 64'h0, lat);
    chk("lat_dbz", 128'(lat), 128'(1));
    res1("dbz", '0, '0, 1'b1);
    release1("dbz");

    // x^8 mod AES polynomial
    op1(127'h100, 64'h11B, lat);
    res1("aes", 127'h1, 64'h1B, 1'b0);
    release1("aes");

    // Hold results in DONE with out_ready low
    op1(127'h7, 64'h3, lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_ov", 128'(out_valid), 128'(1));
      chk("hold_rdy", 128'(in_ready), 128'(0));
      chk("hold_q", {1'b0, quotient}, 128'h2);
    end
    // in_valid during the output handshake must not be taken
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; dividend = 127'h5; divisor = 64'h3;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("ovl_rdy", 128'(in_ready), 128'(1));
    chk("ovl_ov", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    chk("ovl_idle", 128'(in_ready), 128'(1));

    // Reset in the middle of RUN
    @(negedge clk);
    in_valid = 1'b1; dividend = {127{1'b1}}; divisor = 64'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("mrst_ov", 128'(out_valid), 128'(0));
    chk("mrst_rdy", 128'(in_ready), 128'(1));
    res1("mrst", '0, '0, 1'b0);
    repeat (130) @(posedge clk);
    #1;
    chk("mrst_nopulse", 128'(out_valid), 128'(0));
    op1(127'h5, 64'h3, lat);
    res1("after_rst", 127'h3, 64'h0, 1'b0);
    release1("after_rst");

    // Round trip through a carry-less multiply
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (b == 64'h0) b = 64'h1;
      op1(clmul(a, b), b, lat);
      res1("rtrip", {63'b0, a}, 64'h0, 1'b0);
      release1("rtrip");
    end

    for (int i = 0; i < 8; i++) begin
      wide = {$urandom, $urandom, $urandom, $urandom};
      rnd  = wide[126:0];
      ref_div(rnd, 64'h8000_0000_0000_001B, eq, er);
      op1(rnd, 64'h8000_0000_0000_001B, lat);
      res1("red64", eq, er, 1'b0);
      release1("red64");
    end

    // STEPS=4 instance
    op4(127'h5, 64'h3, lat);
    chk("lat_s4", 128'(lat), 128'(33));
    chk("s4_q", {1'b0, quotient4}, 128'h3);
    chk("s4_r", 128'(remainder4), 128'h0);
    release4("s4");
    for (int i = 0; i < 6; i++) begin
      wide = {$urandom, $urandom, $urandom, $urandom};
      rnd  = wide[126:0];
      b    = (i % 2 == 0) ? 64'h8000_0000_0000_001B : ({$urandom, $urandom} | 64'h1);
      ref_div(rnd, b, eq, er);
      op4(rnd, b, lat);
      chk("s4rnd_q", {1'b0, quotient4}, {1'b0, eq});
      chk("s4rnd_r", 128'(remainder4), 128'(er));
      chk("s4rnd_dbz", 128'(dbz4), 128'(0));
      release4("s4rnd");
    end
    op4({127{1'b1}}, 64'h0, lat);
    chk("s4_dbz_lat", 128'(lat), 128'(1));
    chk("s4_dbz", 128'(dbz4), 128'(1));
    release4("s4dbz");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
